stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter WRAP, default 1: 1 = roll 99:59 -> 00:00; 0 = saturate at 99:59 and enter PAUSE.
REQ-002 SHALL have port clk  in  1  single system clock; all state on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port tick_1hz  in  1  one-cycle count strobe.
REQ-005 SHALL have port tick_adj  in  1  one-cycle adjust-rate strobe.
REQ-006 SHALL have port btn_pause  in  1  debounced one-cycle start/pause pulse.
REQ-007 SHALL have port btn_clr  in  1  debounced one-cycle clear pulse.
REQ-008 SHALL have port adj  in  1  level; adjust mode request.
REQ-009 SHALL have port sel  in  1  level; 0 = adjust minutes, 1 = adjust seconds.
REQ-010 SHALL have ports min_l, min_r, sec_l, sec_r  out  5 each  BCD digits for the display block.
REQ-011 SHALL have port running  out  1  high only in RUN.
REQ-012 SHALL have port blink  out  1  blank strobe for the selected field in ADJ.
REQ-013 SHALL have port state  out  2  IDLE=0, RUN=1, PAUSE=2, ADJ=3.

Function
REQ-014 SHALL implement FSM IDLE/RUN/PAUSE/ADJ, registered; all outputs registered.
REQ-015 Transitions SHALL be:
- IDLE --btn_pause--> RUN
- RUN --btn_pause--> PAUSE
- PAUSE --btn_pause--> RUN
- any non-ADJ state --adj=1--> ADJ
- ADJ --adj=0--> PAUSE
REQ-016 btn_clr SHALL, in any state, zero all digits and go to IDLE next cycle; it has highest priority over every other input.
REQ-017 adj=1 SHALL take priority over btn_pause; btn_pause SHALL be ignored in ADJ.
REQ-018 In RUN, each tick_1hz SHALL advance time by one second, visible on the digits the cycle after the strobe.
REQ-019 Digit ranges SHALL be sec_r 0-9, sec_l 0-5, min_r 0-9, min_l 0-9. Carry SHALL ripple sec_r -> sec_l -> min_r -> min_l within that single cycle. Bits [4] of every digit SHALL be 0.
REQ-020 At 99:59 with tick_1hz:
- WRAP=1: digits SHALL become 00:00 and remain in RUN.
- WRAP=0: digits SHALL hold 99:59 and FSM SHALL go to PAUSE.
REQ-021 tick_1hz outside RUN SHALL be ignored.
REQ-022 When tick_1hz and btn_pause coincide in RUN, the tick SHALL be counted and the FSM SHALL enter PAUSE.
REQ-023 In ADJ, each tick_adj SHALL increment the selected field:
- sel=0: minutes 00..99, wrapping to 00.
- sel=1: seconds 00..59, wrapping to 00.
- No carry SHALL pass between the two fields.
REQ-024 sel change in ADJ SHALL take effect on the next tick_adj; no digit change SHALL occur on the change itself.
REQ-025 blink SHALL toggle on each tick_adj while in ADJ and SHALL be 0 in every other state.
REQ-026 On ADJ entry, blink SHALL be 0.

Reset
REQ-027 rst_n=0 SHALL immediately force:
- state=IDLE
- all digits=0
- running=0
- blink=0
REQ-028 Reset SHALL override any operation mid-count or mid-adjust; nothing SHALL be retained.
REQ-029 First input action SHALL be taken on the first rising edge with rst_n=1.

Verification
REQ-030 Bench SHALL cover: btn_pause then 61 tick_1hz -> digits 01:01, running=1.
REQ-031 Bench SHALL cover: preload 99:59 via ADJ, resume, one tick_1hz -> WRAP=1 gives 00:00 in RUN; WRAP=0 gives 99:59 and state=2.
REQ-032 Bench SHALL cover: in RUN, tick_1hz and btn_pause in the same cycle at 00:09 -> 00:10, state=PAUSE; further ticks leave 00:10.
REQ-033 Bench SHALL cover: adj=1, sel=1, 60 tick_adj from 00:00 -> 00:00 with minutes untouched; then sel=0, 3 tick_adj -> 03:00; adj=0 -> state=PAUSE, blink=0.
REQ-034 Bench SHALL cover: btn_clr and btn_pause in the same cycle during RUN at 12:34 -> 00:00, state=IDLE.
REQ-035 Bench SHALL cover: rst_n pulsed low between clock edges during ADJ -> outputs zero/IDLE before the next edge.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch controller: IDLE/RUN/PAUSE/ADJ state machine with BCD time
// digits, 1 Hz counting in RUN and per-field time setting in ADJ.
module stopwatch_ctrl #(
    parameter bit WRAP = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       tick_adj,
    input  logic       btn_pause,
    input  logic       btn_clr,
    input  logic       adj,
    input  logic       sel,
    output logic [4:0] min_l,
    output logic [4:0] min_r,
    output logic [4:0] sec_l,
    output logic [4:0] sec_r,
    output logic       running,
    output logic       blink,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_ADJ   = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] min_l_q, min_l_d;
    logic [3:0] min_r_q, min_r_d;
    logic [3:0] sec_l_q, sec_l_d;
    logic [3:0] sec_r_q, sec_r_d;
    logic       running_q, running_d;
    logic       blink_q, blink_d;
    logic       at_max;

    assign at_max = (min_l_q == 4'd9) && (min_r_q == 4'd9) &&
                    (sec_l_q == 4'd5) && (sec_r_q == 4'd9);

    always_comb begin
        state_d   = state_q;
        min_l_d   = min_l_q;
        min_r_d   = min_r_q;
        sec_l_d   = sec_l_q;
        sec_r_d   = sec_r_q;
        blink_d   = blink_q;
        running_d = 1'b0;

        if (btn_clr) begin
            state_d = S_IDLE;
            min_l_d = '0;
            min_r_d = '0;
            sec_l_d = '0;
            sec_r_d = '0;
        end else begin
            case (state_q)
                S_IDLE, S_PAUSE: begin
                    if (adj)
                        state_d = S_ADJ;
                    else if (btn_pause)
                        state_d = S_RUN;
                end
                S_RUN: begin
                    // The tick is counted first; a coincident adj/btn_pause then
                    // overrides the saturation-driven PAUSE with the same or a
                    // stronger target.
                    if (tick_1hz) begin
                        if (at_max && !WRAP) begin
                            state_d = S_PAUSE;
                        end else if (sec_r_q != 4'd9) begin
                            sec_r_d = sec_r_q + 4'd1;
                        end else begin
                            sec_r_d = '0;
                            if (sec_l_q != 4'd5) begin
                                sec_l_d = sec_l_q + 4'd1;
                            end else begin
                                sec_l_d = '0;
                                if (min_r_q != 4'd9) begin
                                    min_r_d = min_r_q + 4'd1;
                                end else begin
                                    min_r_d = '0;
                                    min_l_d = (min_l_q != 4'd9) ? min_l_q + 4'd1 : '0;
                                end
                            end
                        end
                    end
                    if (adj)
                        state_d = S_ADJ;
                    else if (btn_pause)
                        state_d = S_PAUSE;
                end
                S_ADJ: begin
                    if (!adj) begin
                        state_d = S_PAUSE;
                    end else if (tick_adj) begin
                        blink_d = ~blink_q;
                        if (sel) begin
                            if (sec_r_q != 4'd9) begin
                                sec_r_d = sec_r_q + 4'd1;
                            end else begin
                                sec_r_d = '0;
                                sec_l_d = (sec_l_q != 4'd5) ? sec_l_q + 4'd1 : '0;
                            end
                        end else begin
                            if (min_r_q != 4'd9) begin
                                min_r_d = min_r_q + 4'd1;
                            end else begin
                                min_r_d = '0;
                                min_l_d = (min_l_q != 4'd9) ? min_l_q + 4'd1 : '0;
                            end
                        end
                    end
                end
            endcase
        end

        // blink is only meaningful while staying in ADJ; it restarts at 0 on entry
        if (state_d != S_ADJ || state_q != S_ADJ)
            blink_d = 1'b0;
        running_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            min_l_q   <= '0;
            min_r_q   <= '0;
            sec_l_q   <= '0;
            sec_r_q   <= '0;
            running_q <= 1'b0;
            blink_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_l_q   <= min_l_d;
            min_r_q   <= min_r_d;
            sec_l_q   <= sec_l_d;
            sec_r_q   <= sec_r_d;
            running_q <= running_d;
            blink_q   <= blink_d;
        end
    end

    assign min_l   = {1'b0, min_l_q};
    assign min_r   = {1'b0, min_r_q};
    assign sec_l   = {1'b0, sec_l_q};
    assign sec_r   = {1'b0, sec_r_q};
    assign running = running_q;
    assign blink   = blink_q;
    assign state   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: a vector table plus hand-written sequences,
// with a WRAP=1 and a WRAP=0 instance driven from the same stimulus.
module tb_stopwatch_ctrl;

    logic clk, rst_n;
    logic tick_1hz, tick_adj, btn_pause, btn_clr, adj, sel;
    logic [4:0] w_min_l, w_min_r, w_sec_l, w_sec_r;
    logic [4:0] n_min_l, n_min_r, n_sec_l, n_sec_r;
    logic w_running, w_blink, n_running, n_blink;
    logic [1:0] w_state, n_state;

    int checks = 0;
    int failures = 0;

    stopwatch_ctrl #(.WRAP(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_adj(tick_adj),
        .btn_pause(btn_pause), .btn_clr(btn_clr), .adj(adj), .sel(sel),
        .min_l(w_min_l), .min_r(w_min_r), .sec_l(w_sec_l), .sec_r(w_sec_r),
        .running(w_running), .blink(w_blink), .state(w_state)
    );

    stopwatch_ctrl #(.WRAP(1'b0)) dut_nw (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_adj(tick_adj),
        .btn_pause(btn_pause), .btn_clr(btn_clr), .adj(adj), .sel(sel),
        .min_l(n_min_l), .min_r(n_min_r), .sec_l(n_sec_l), .sec_r(n_sec_r),
        .running(n_running), .blink(n_blink), .state(n_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       clr, pse, tk, ta, ad, sl;
        logic [1:0] st;
        logic [15:0] dg;
        logic       run, bl;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [19:0] bcd20(input logic [15:0] d);
        return {1'b0, d[15:12], 1'b0, d[11:8], 1'b0, d[7:4], 1'b0, d[3:0]};
    endfunction

    task automatic cmp(input string nm, input logic [19:0] act, input logic [19:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // Full check of the WRAP=1 instance
    task automatic chk(input string nm, input logic [1:0] es, input logic [15:0] ed,
                       input logic er, input logic eb);
        cmp({nm, ".digits"}, {w_min_l, w_min_r, w_sec_l, w_sec_r}, bcd20(ed));
        cmp({nm, ".state"}, {18'd0, w_state}, {18'd0, es});
        cmp({nm, ".running"}, {19'd0, w_running}, {19'd0, er});
        cmp({nm, ".blink"}, {19'd0, w_blink}, {19'd0, eb});
    endtask

    task automatic chk_nw(input string nm, input logic [1:0] es, input logic [15:0] ed,
                          input logic er);
        cmp({nm, ".nw_digits"}, {n_min_l, n_min_r, n_sec_l, n_sec_r}, bcd20(ed));
        cmp({nm, ".nw_state"}, {18'd0, n_state}, {18'd0, es});
        cmp({nm, ".nw_running"}, {19'd0, n_running}, {19'd0, er});
    endtask

    task automatic cyc(input logic c, input logic p, input logic t, input logic ta,
                       input logic a, input logic s);
        btn_clr = c; btn_pause = p; tick_1hz = t; tick_adj = ta; adj = a; sel = s;
        @(posedge clk);
        #1;
        btn_clr = 1'b0; btn_pause = 1'b0; tick_1hz = 1'b0; tick_adj = 1'b0;
    endtask

    // Sets the time via ADJ from IDLE/PAUSE and leaves the FSM in PAUSE
    task automatic preload(input int unsigned mins, input int unsigned secs);
        cyc(0, 0, 0, 0, 1, 0);
        for (int unsigned i = 0; i < mins; i++) cyc(0, 0, 0, 1, 1, 0);
        for (int unsigned i = 0; i < secs; i++) cyc(0, 0, 0, 1, 1, 1);
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        btn_clr = 0; btn_pause = 0; tick_1hz = 0; tick_adj = 0; adj = 0; sel = 0;

        //          clr pse tk ta ad sl  st     digits    run bl
        vecs[0]  = '{0, 1, 0, 0, 0, 0, 2'd1, 16'h0000, 1, 0};
        vecs[1]  = '{0, 0, 1, 0, 0, 0, 2'd1, 16'h0001, 1, 0};
        vecs[2]  = '{0, 0, 1, 0, 0, 0, 2'd1, 16'h0002, 1, 0};
        vecs[3]  = '{0, 0, 0, 0, 0, 0, 2'd1, 16'h0002, 1, 0};
        vecs[4]  = '{0, 1, 0, 0, 0, 0, 2'd2, 16'h0002, 0, 0};
        vecs[5]  = '{0, 0, 1, 0, 0, 0, 2'd2, 16'h0002, 0, 0};
        vecs[6]  = '{0, 1, 0, 0, 0, 0, 2'd1, 16'h0002, 1, 0};
        vecs[7]  = '{0, 1, 0, 0, 1, 0, 2'd3, 16'h0002, 0, 0};
        vecs[8]  = '{0, 0, 0, 1, 1, 0, 2'd3, 16'h0102, 0, 1};
        vecs[9]  = '{0, 0, 0, 0, 1, 1, 2'd3, 16'h0102, 0, 1};
        vecs[10] = '{0, 0, 0, 1, 1, 1, 2'd3, 16'h0103, 0, 0};
        vecs[11] = '{0, 1, 0, 0, 1, 1, 2'd3, 16'h0103, 0, 0};
        vecs[12] = '{0, 0, 1, 0, 1, 1, 2'd3, 16'h0103, 0, 0};
        vecs[13] = '{0, 0, 0, 0, 0, 1, 2'd2, 16'h0103, 0, 0};
        vecs[14] = '{1, 0, 0, 0, 0, 0, 2'd0, 16'h0000, 0, 0};
        vecs[15] = '{0, 0, 1, 0, 0, 0, 2'd0, 16'h0000, 0, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset", 2'd0, 16'h0000, 0, 0);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            cyc(vecs[i].clr, vecs[i].pse, vecs[i].tk, vecs[i].ta, vecs[i].ad, vecs[i].sl);
            chk($sformatf("vec%0d", i), vecs[i].st, vecs[i].dg, vecs[i].run, vecs[i].bl);
        end

        // 61 seconds from zero
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 61; i++) begin
            cyc(0, 0, 1, 0, 0, 0);
            if (i == 9) chk("run_10s", 2'd1, 16'h0010, 1, 0);
        end
        chk("run_61s", 2'd1, 16'h0101, 1, 0);

        // Minute carry across 09:59
        cyc(1, 0, 0, 0, 0, 0);
        preload(9, 59);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("carry_0959", 2'd1, 16'h1000, 1, 0);

        // Rollover at 99:59 for both WRAP settings
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 99; i++) cyc(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 59; i++) cyc(0, 0, 0, 1, 1, 1);
        chk("adj_9959", 2'd3, 16'h9959, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("resume_9959", 2'd1, 16'h9959, 1, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("wrap", 2'd1, 16'h0000, 1, 0);
        chk_nw("sat", 2'd2, 16'h9959, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk_nw("sat_hold", 2'd2, 16'h9959, 0);

        // Tick and pause in the same cycle
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) cyc(0, 0, 1, 0, 0, 0);
        chk("at_0009", 2'd1, 16'h0009, 1, 0);
        cyc(0, 1, 1, 0, 0, 0);
        chk("tick_pause", 2'd2, 16'h0010, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0);
        chk("paused_ticks", 2'd2, 16'h0010, 0, 0);

        // Seconds field wraps without touching minutes
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1);
        chk("adj_entry", 2'd3, 16'h0000, 0, 0);
        for (int i = 0; i < 60; i++) cyc(0, 0, 0, 1, 1, 1);
        chk("sec_wrap", 2'd3, 16'h0000, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1, 0);
        chk("min_adj", 2'd3, 16'h0300, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("adj_exit", 2'd2, 16'h0300, 0, 0);

        // Clear beats pause at 12:34 in RUN
        cyc(1, 0, 0, 0, 0, 0);
        preload(12, 34);
        cyc(0, 1, 0, 0, 0, 0);
        chk("run_1234", 2'd1, 16'h1234, 1, 0);
        cyc(1, 1, 0, 0, 0, 0);
        chk("clr_pause", 2'd0, 16'h0000, 0, 0);

        // Asynchronous reset mid-adjust
        cyc(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1, 1);
        chk("pre_rst", 2'd3, 16'h0003, 0, 1);
        adj = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst", 2'd0, 16'h0000, 0, 0);
        chk_nw("async_rst", 2'd0, 16'h0000, 0);
        #2 rst_n = 1'b1;
        cyc(0, 1, 0, 0, 0, 0);
        chk("post_rst", 2'd1, 16'h0000, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
